// File: rtl/collision_hp_ctrl.sv
// collision_hp_ctrl: per-frame player/bullet hit arbiter, HP counter and invulnerability timer.
// Optional macro COLLISION_BLINK_EN builds a 3-bit frame counter that drives the blink mask.
module collision_hp_ctrl #(
  parameter int NB            = 2,
  parameter int HP_W          = 7,
  parameter int HP_MAX        = 100,
  parameter int DAMAGE        = 20,
  parameter int INVULN_FRAMES = 30
) (
  input  logic            Pclk,
  input  logic            RESET,
  input  logic            frame_tick,
  input  logic            aactive,
  input  logic            bee_on,
  input  logic [NB-1:0]   bullet_on,
  input  logic            state_game,
  output logic            hit_pulse,
  output logic [2:0]      hit_src,
  output logic [HP_W-1:0] player_hp,
  output logic            invuln,
  output logic            dead,
  output logic            blink
);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_e;

  localparam logic [HP_W-1:0] HP_INIT  = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0] HP_DMG   = HP_W'(DAMAGE);
  localparam logic [7:0]      INV_LOAD = 8'(INVULN_FRAMES);

  state_e          state_q, state_d;
  logic [NB-1:0]   overlap_acc_q, overlap_acc_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [7:0]      inv_cnt_q, inv_cnt_d;
  logic [2:0]      hit_src_q, hit_src_d;
  logic [2:0]      low_idx;
  logic            hit_pulse_q, hit_pulse_d;
  logic            state_game_q;
  logic            acc_clr;
  logic            sample_en;

  // Any phase change or frame boundary drops whatever was collected so far.
  assign acc_clr   = frame_tick | (state_game ^ state_game_q);
  assign sample_en = aactive & ~state_game & bee_on;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_acc
      assign overlap_acc_d[gi] = acc_clr ? 1'b0
                               : (overlap_acc_q[gi] | (sample_en & bullet_on[gi]));
    end
  endgenerate

  always_comb begin
    low_idx = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (overlap_acc_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    inv_cnt_d   = inv_cnt_q;
    hit_src_d   = hit_src_q;
    hit_pulse_d = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ALIVE: begin
          if (|overlap_acc_q) begin
            hp_d        = (hp_q > HP_DMG) ? hp_q - HP_DMG : '0;
            hit_src_d   = low_idx;
            hit_pulse_d = 1'b1;
            inv_cnt_d   = INV_LOAD;
            state_d     = (hp_q > HP_DMG) ? INVULN : DEAD;
          end
        end
        INVULN: begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          if (inv_cnt_q == 8'd1) state_d = ALIVE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Pclk) begin
    if (RESET) begin
      state_q       <= ALIVE;
      overlap_acc_q <= '0;
      hp_q          <= HP_INIT;
      inv_cnt_q     <= '0;
      hit_src_q     <= '0;
      hit_pulse_q   <= 1'b0;
      state_game_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      overlap_acc_q <= overlap_acc_d;
      hp_q          <= hp_d;
      inv_cnt_q     <= inv_cnt_d;
      hit_src_q     <= hit_src_d;
      hit_pulse_q   <= hit_pulse_d;
      state_game_q  <= state_game;
    end
  end

  assign hit_pulse = hit_pulse_q;
  assign hit_src   = hit_src_q;
  assign player_hp = hp_q;
  assign invuln    = (state_q == INVULN);
  assign dead      = (state_q == DEAD);

`ifdef COLLISION_BLINK_EN
  logic [2:0] frame_cnt_q;

  always_ff @(posedge Pclk) begin
    if (RESET) frame_cnt_q <= '0;
    else if (frame_tick) frame_cnt_q <= frame_cnt_q + 3'd1;
  end

  assign blink = invuln & frame_cnt_q[2];
`else
  assign blink = 1'b0;
`endif

endmodule
